// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between NUM_CH clients.
// Each client owns an auto-incrementing address pointer. Read returns are
// in order and go back to the issuing channel through a small tag FIFO.
module mem_port_arbiter #(
  parameter int unsigned       NUM_CH          = 4,
  parameter int unsigned       DATA_W          = 256,
  parameter int unsigned       ADDR_W          = 32,
  parameter int unsigned       ADDR_STRIDE     = 32,
  parameter int unsigned       BURST_MAX       = 16,
  parameter int unsigned       LEN_W           = 5,
  parameter int unsigned       MAX_OUTSTANDING = 8,
  parameter logic [NUM_CH-1:0] WRITE_MASK      = 4'b0100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH*ADDR_W-1:0] base_addr_in,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_wack,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [NUM_CH-1:0]        ch_grant,
  output logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_read_data,
  input  logic                     mem_valid,
  output logic                     idle,
  output logic                     error
);

  localparam int unsigned OWN_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W      = $clog2(BURST_MAX + 1);
  localparam int unsigned PTR_W      = $clog2(MAX_OUTSTANDING);
  localparam int unsigned FIFO_CNT_W = PTR_W + 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  localparam logic [OWN_W-1:0]      LAST_CH    = OWN_W'(NUM_CH - 1);
  localparam logic [FIFO_CNT_W-1:0] FIFO_DEPTH = FIFO_CNT_W'(MAX_OUTSTANDING);

  logic [0:0]       state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             error_q, error_d;

  logic [OWN_W-1:0] grant_idx, cand;
  logic             grant_found;
  logic [CNT_W-1:0] len_clamped;

  logic in_burst, is_write, accept, start_ok;

  logic [ADDR_W-1:0] ptr_q     [NUM_CH];
  logic [ADDR_W-1:0] base_arr  [NUM_CH];
  logic [DATA_W-1:0] wdata_arr [NUM_CH];
  logic [LEN_W-1:0]  len_arr   [NUM_CH];

  logic [OWN_W-1:0]      tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  fifo_empty, fifo_full, push, pop;
  logic [OWN_W-1:0]      rtag;

  // Unpack the flat per-channel buses and pack the pointer view.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign base_arr[g]  = base_addr_in[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = ch_wdata[g*DATA_W +: DATA_W];
    assign len_arr[g]   = ch_len[g*LEN_W +: LEN_W];
    assign ch_addr[g*ADDR_W +: ADDR_W] = ptr_q[g];
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_DEPTH);
  assign idle       = (state_q == StIdle) && fifo_empty;
  assign error      = error_q;
  assign start_ok   = start && idle;

  // Round-robin search starting just after the last grantee.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = OWN_W'((32'(last_q) + k) % NUM_CH);
      if (!grant_found && ch_req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Requested length: zero means one beat, long requests saturate at BURST_MAX.
  always_comb begin
    len_clamped = CNT_W'(BURST_MAX);
    if (len_arr[grant_idx] == '0) begin
      len_clamped = CNT_W'(1);
    end else if (32'(len_arr[grant_idx]) <= BURST_MAX) begin
      len_clamped = CNT_W'(len_arr[grant_idx]);
    end
  end

  // Memory-side beat issue for the current owner.
  always_comb begin
    in_burst       = (state_q == StBurst);
    is_write       = WRITE_MASK[owner_q];
    ch_grant       = '0;
    ch_wack        = '0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (in_burst) begin
      ch_grant[owner_q] = 1'b1;
      mem_addr          = ptr_q[owner_q];
      if (is_write) begin
        mem_write      = 1'b1;
        mem_write_data = wdata_arr[owner_q];
      end else begin
        // Never issue a read whose tag could not be stored.
        mem_read = !fifo_full;
      end
    end
    accept = (mem_read || mem_write) && mem_ready;
    if (accept && is_write) begin
      ch_wack[owner_q] = 1'b1;
    end
  end

  // Read-return routing from the tag FIFO head.
  always_comb begin
    rtag      = tag_mem[rd_ptr_q];
    push      = accept && !is_write;
    pop       = mem_valid && !fifo_empty;
    ch_rvalid = '0;
    ch_rdata  = '0;
    if (pop) begin
      ch_rvalid[rtag] = 1'b1;
      ch_rdata        = mem_read_data;
    end
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + FIFO_CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - FIFO_CNT_W'(1);
    end
  end

  // Burst FSM next state and sticky error.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beats_d = beats_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          state_d = StBurst;
          owner_d = grant_idx;
          beats_d = len_clamped;
        end
      end
      StBurst: begin
        if (accept) begin
          beats_d = beats_q - CNT_W'(1);
          if (beats_q == CNT_W'(1)) begin
            state_d = StIdle;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    error_d = error_q || (start && !idle) || (mem_valid && fifo_empty);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= LAST_CH;
      beats_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      error_q <= error_d;
    end
  end

  // Per-channel address pointers: bulk load on start, advance on each accepted beat.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        ptr_q[i] <= '0;
      end else if (start_ok) begin
        ptr_q[i] <= base_arr[i];
      end else if (accept && (owner_q == OWN_W'(i))) begin
        ptr_q[i] <= ptr_q[i] + ADDR_W'(ADDR_STRIDE);
      end
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Tag FIFO storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= owner_q;
    end
  end

endmodule
